// File: rtl/bcd_scan_display.sv
// Sequential shift-add-3 binary-to-BCD converter
// with a multiplexed active-low 7-segment scanner.
module bcd_scan_display #(
  parameter int WIDTH    = 6,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    data,
  input  logic                lzb,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [4*DIGITS-1:0] bcd,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] seg_of(logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    work;
  logic [BW-1:0]    work_adj;
  logic [BW-1:0]    work_nx;
  logic [CW-1:0]    cnt;
  logic             ovf_pend;
  logic             last;

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CONVERT;
      CONVERT: if (last)  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONVERT);
  end

  // Add-3 correction before the shift keeps each nibble a valid digit.
  always_comb begin
    work_adj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5)
        work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
  end

  assign work_nx = {work_adj[BW-2:0], sh[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh       <= data;
            work     <= '0;
            cnt      <= CW'(WIDTH);
            ovf_pend <= (64'(data) >= LIMIT);
          end
        end
        CONVERT: begin
          sh   <= sh << 1;
          work <= work_nx;
          cnt  <= cnt - CW'(1);
          if (last) begin
            bcd      <= work_nx;
            overflow <= ovf_pend;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

  logic [DW-1:0]     div;
  logic [IW-1:0]     idx;
  logic [3:0]        cur;
  logic [DIGITS-1:0] zero_up;
  logic              blank;
  logic [6:0]        seg_nx;

  // zero_up[k]: digit k and every higher digit are zero.
  always_comb begin
    zero_up = '0;
    zero_up[DIGITS-1] = (bcd[BW-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      zero_up[k] = zero_up[k+1] && (bcd[4*k +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur   = '0;
    blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur   = bcd[4*k +: 4];
        blank = zero_up[k] && (k != 0);
      end
    end
  end

  always_comb begin
    if (overflow)        seg_nx = 7'b1111110;
    else if (lzb && blank) seg_nx = 7'b1111111;
    else                 seg_nx = seg_of(cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      seg <= 7'b1111111;
      an  <= '1;
    end else begin
      seg <= seg_nx;
      an  <= ~(DIGITS'(1) << idx);
      if (div == DW'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule
